// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state and client types for the BRAM arbiter/clear controller.
package bram_arb_pkg;
    typedef enum logic {ARB, CLEAR} state_e;
    typedef enum logic {CLI_A = 1'b0, CLI_B = 1'b1} client_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ptr names the client that wins a tie.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  client_e    ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[0] = req[0] & (~req[1] | (ptr == CLI_A));
        gnt[1] = req[1] & (~req[0] | (ptr == CLI_B));
    end
endmodule

// File: rtl/bram_arb_ctrl.sv
// bram_arb_ctrl: arbitrates two clients onto an external 1-cycle simple-dual-port RAM
// and sweeps the whole RAM with FILL_VAL on request or after reset.
module bram_arb_ctrl
    import bram_arb_pkg::*;
#(
    parameter int                 WID_MEM        = 1,
    parameter int                 DEPTH_MEM      = 32768,
    parameter int                 AW             = 15,
    parameter logic [WID_MEM-1:0] FILL_VAL       = '0,
    parameter bit                 CLEAR_ON_RESET = 1'b1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_start,
    output logic               busy,
    input  logic               a_req,
    input  logic               b_req,
    input  logic               a_we,
    input  logic               b_we,
    input  logic [AW-1:0]      a_addr,
    input  logic [AW-1:0]      b_addr,
    input  logic [WID_MEM-1:0] a_wdata,
    input  logic [WID_MEM-1:0] b_wdata,
    output logic               a_gnt,
    output logic               b_gnt,
    output logic               a_rvalid,
    output logic               b_rvalid,
    output logic [WID_MEM-1:0] a_rdata,
    output logic [WID_MEM-1:0] b_rdata,
    output logic [AW-1:0]      mem_raddr,
    output logic [AW-1:0]      mem_waddr,
    output logic               mem_we,
    output logic [WID_MEM-1:0] mem_din,
    input  logic [WID_MEM-1:0] mem_dout
);
    localparam state_e        RST_STATE = CLEAR_ON_RESET ? CLEAR : ARB;
    localparam logic [AW-1:0] LAST      = AW'(DEPTH_MEM - 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    client_e            prio_q, prio_d;
    logic [1:0]         rd_q, rd_d, gnt;
    logic [WID_MEM-1:0] a_rdata_q, b_rdata_q;
    logic               arb_en, sel_b, acc_we;
    logic [AW-1:0]      acc_addr;

    // Gating with reset keeps grants low while reset is held, even when resetting into ARB.
    assign arb_en = reset & (state_q == ARB);

    rr_arb2 u_arb (
        .req ({b_req, a_req} & {2{arb_en}}),
        .ptr (prio_q),
        .gnt (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = gnt[0] ? CLI_B : (gnt[1] ? CLI_A : prio_q);
        sel_b     = gnt[1];
        acc_we    = sel_b ? b_we : a_we;
        acc_addr  = sel_b ? b_addr : a_addr;
        rd_d      = gnt & ~{b_we, a_we};
        mem_we    = |gnt & acc_we;
        mem_waddr = mem_we ? acc_addr : '0;
        mem_raddr = (|gnt & ~acc_we) ? acc_addr : '0;
        mem_din   = mem_we ? (sel_b ? b_wdata : a_wdata) : '0;
        if (state_q == ARB) begin
            state_d = clear_start ? CLEAR : ARB;
            cnt_d   = '0;
        end else begin
            mem_we    = reset;
            mem_waddr = cnt_q;
            mem_din   = FILL_VAL;
            cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            state_d   = (cnt_q == LAST) ? ARB : CLEAR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            prio_q    <= CLI_A;
            rd_q      <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            rd_q    <= rd_d;
            if (rd_q[0]) a_rdata_q <= mem_dout;
            if (rd_q[1]) b_rdata_q <= mem_dout;
        end
    end

    // Read data is passed straight through in the valid cycle and held afterwards.
    assign a_gnt    = gnt[0];
    assign b_gnt    = gnt[1];
    assign busy     = (state_q == CLEAR);
    assign a_rvalid = rd_q[0];
    assign b_rvalid = rd_q[1];
    assign a_rdata  = rd_q[0] ? mem_dout : a_rdata_q;
    assign b_rdata  = rd_q[1] ? mem_dout : b_rdata_q;
endmodule

// File: tb/tb_bram_arb_ctrl.sv
// tb_bram_arb_ctrl: bram_arb_ctrl with a read-first 1-cycle RAM, a reference model of
// memory contents/arbitration, and a scoreboard monitor for read returns.
module tb_bram_arb_ctrl;
    localparam int W = 8, D = 32768, AW = 15;
    typedef struct { int cyc; logic [W-1:0] data; } exp_t;

    logic          clk = 0, reset = 1, clear_start = 0, busy;
    logic          a_req = 0, b_req = 0, a_we = 0, b_we = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0, mem_raddr, mem_waddr;
    logic [W-1:0]  a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, mem_din, mem_dout = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we;
    logic [W-1:0]  ram [D];
    logic [W-1:0]  mdl [D];
    logic [W-1:0]  last_a = '0, last_b = '0;
    exp_t          qa[$], qb[$];
    int            cyc = 0, n_cmp = 0, n_bad = 0;
    bit            busy_m = 1;
    int            cnt_m = 0, pri_m = 0, g_m = -1;

    bram_arb_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .AW(AW), .FILL_VAL(8'h00), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .clear_start(clear_start), .busy(busy),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_din;
        mem_dout <= ram[mem_raddr];
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    // Scoreboard monitor: every rvalid must match the oldest expected read of that client.
    always @(negedge clk) begin
        if (reset) begin
            if (a_rvalid) begin
                if (qa.size() == 0) chk("a_rvalid_spurious", a_rvalid, 0);
                else begin
                    chk("a_rvalid_cycle", cyc, qa[0].cyc);
                    chk("a_rdata", a_rdata, qa[0].data);
                    void'(qa.pop_front());
                end
                last_a = a_rdata;
            end else begin
                chk("a_rdata_hold", a_rdata, last_a);
                if (qa.size() != 0 && qa[0].cyc <= cyc) begin
                    chk("a_rvalid_missing", a_rvalid, 1);
                    void'(qa.pop_front());
                end
            end
            if (b_rvalid) begin
                if (qb.size() == 0) chk("b_rvalid_spurious", b_rvalid, 0);
                else begin
                    chk("b_rvalid_cycle", cyc, qb[0].cyc);
                    chk("b_rdata", b_rdata, qb[0].data);
                    void'(qb.pop_front());
                end
                last_b = b_rdata;
            end else begin
                chk("b_rdata_hold", b_rdata, last_b);
                if (qb.size() != 0 && qb[0].cyc <= cyc) begin
                    chk("b_rvalid_missing", b_rvalid, 1);
                    void'(qb.pop_front());
                end
            end
        end
    end

    // One clock of the reference model: predicts grant, RAM port use and read returns.
    task automatic step();
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wd;
        exp_t          e;
        @(negedge clk);
        chk("busy", busy, busy_m);
        g_m = -1;
        if (busy_m) begin
            chk("clr_gnt", {b_gnt, a_gnt}, 0);
            chk("clr_we", mem_we, 1);
            chk("clr_waddr", mem_waddr, cnt_m);
            chk("clr_din", mem_din, 0);
            mdl[cnt_m] = '0;
            cnt_m++;
            if (cnt_m == D) begin
                busy_m = 0;
                cnt_m = 0;
            end
        end else begin
            if (a_req && b_req) g_m = pri_m;
            else if (a_req) g_m = 0;
            else if (b_req) g_m = 1;
            chk("gnt", {b_gnt, a_gnt}, g_m < 0 ? 0 : (g_m == 0 ? 1 : 2));
            if (g_m < 0) begin
                chk("idle_we", mem_we, 0);
                chk("idle_addr", {mem_waddr, mem_raddr}, 0);
            end else begin
                we   = g_m ? b_we : a_we;
                addr = g_m ? b_addr : a_addr;
                wd   = g_m ? b_wdata : a_wdata;
                if (we) begin
                    chk("wr_we", mem_we, 1);
                    chk("wr_addr", mem_waddr, addr);
                    chk("wr_din", mem_din, wd);
                    mdl[addr] = wd;
                end else begin
                    chk("rd_we", mem_we, 0);
                    chk("rd_addr", mem_raddr, addr);
                    e = '{cyc + 1, mdl[addr]};
                    if (g_m == 1) qb.push_back(e);
                    else qa.push_back(e);
                end
                pri_m = 1 - g_m;
            end
            if (clear_start) busy_m = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        qa.delete();
        qb.delete();
        busy_m = 1;
        cnt_m = 0;
        pri_m = 0;
        last_a = '0;
        last_b = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", {b_gnt, a_gnt}, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_busy", busy, 1);
            chk("rst_rvalid", {b_rvalid, a_rvalid}, 0);
            chk("rst_rdata", {b_rdata, a_rdata}, 0);
        end
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic sweep();
        int n = 0;
        while (busy_m && n < D + 8) begin
            step();
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            ram[i] = 8'hA5;
            mdl[i] = 8'hA5;
        end
        @(posedge clk);
        #1;
        do_reset();
        sweep();
        step();
        a_req = 1; a_we = 1; a_addr = 5; a_wdata = 8'h55;
        step();
        a_req = 0; b_req = 1; b_we = 1; b_addr = 9; b_wdata = 8'h99;
        step();
        a_req = 1; a_we = 0; b_we = 0;
        repeat (6) step();
        b_req = 0; a_we = 1; a_addr = 100; a_wdata = 8'h01;
        step();
        a_req = 0; b_req = 1; b_addr = 100;
        step();
        b_req = 0; a_req = 1; a_wdata = 8'h02;
        step();
        a_req = 0; b_req = 1;
        step();
        b_we = 1;
        for (int i = 0; i < 4; i++) begin
            b_addr = AW'(200 + i);
            b_wdata = W'(i + 3);
            step();
        end
        b_req = 0;
        repeat (3) step();
        a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 200; b_addr = 201;
        repeat (2) step();
        a_req = 0; b_req = 0;
        repeat (400) begin
            if (!a_req || g_m == 0) begin
                a_req = 1'($urandom_range(0, 1));
                a_we = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 15));
                a_wdata = W'($urandom);
            end
            if (!b_req || g_m == 1) begin
                b_req = 1'($urandom_range(0, 1));
                b_we = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 15));
                b_wdata = W'($urandom);
            end
            step();
        end
        a_req = 1; a_we = 0; a_addr = 5; b_req = 0; clear_start = 1;
        step();
        clear_start = 0; b_req = 1; b_we = 0; b_addr = 9;
        while (busy_m && cnt_m < 1000) begin
            clear_start = (cnt_m == 500);
            step();
        end
        clear_start = 0;
        do_reset();
        sweep();
        repeat (4) step();
        a_req = 0; b_req = 0;
        repeat (4) step();
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_arb_ctrl.md
BRAM_ARB_CTRL -- requirements
Module: bram_arb_ctrl

Interface
REQ-001 SHALL have parameter WID_MEM, default 1, RAM word width in bits.
REQ-002 SHALL have parameter DEPTH_MEM, default 32768, RAM depth in words.
REQ-003 SHALL have parameter AW, default 15, address width, with DEPTH_MEM <= 2**AW.
REQ-004 SHALL have parameter FILL_VAL, default 0, WID_MEM-bit word written by the clear engine.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, a clear sweep starts after reset release.
REQ-006 SHALL have ports, in this order:
  clk  in  1  single clock; all logic on the rising edge.
  reset  in  1  asynchronous, active-low reset.
  clear_start  in  1  one-cycle pulse that requests a full clear sweep.
  busy  out  1  high while a clear sweep is in progress.
  a_req/b_req  in  1  client access request.
  a_we/b_we  in  1  1 = write, 0 = read.
  a_addr/b_addr  in  AW  client address.
  a_wdata/b_wdata  in  WID_MEM  client write data.
  a_gnt/b_gnt  out  1  combinational grant; the access executes in this cycle.
  a_rvalid/b_rvalid  out  1  read data valid.
  a_rdata/b_rdata  out  WID_MEM  read data.
  mem_raddr/mem_waddr  out  AW  RAM read and write addresses.
  mem_we  out  1  RAM write enable.
  mem_din  out  WID_MEM  RAM write data.
  mem_dout  in  WID_MEM  RAM registered read data, one-cycle latency.

Function
REQ-007 SHALL implement a two-state FSM, ARB and CLEAR, and SHALL grant at most one client per cycle.
REQ-008 In ARB, a single requester SHALL be granted in the same cycle; on a tie, the client not granted last SHALL win; after reset, A has priority.
REQ-009 The priority pointer SHALL update only on a grant.
REQ-010 Each client SHALL hold req/we/addr/wdata stable until gnt; gnt with req low SHALL never occur.
REQ-011 A granted write SHALL drive mem_we=1, mem_waddr=addr and mem_din=wdata in the grant cycle.
REQ-012 A granted read SHALL drive mem_raddr=addr in the grant cycle, with mem_we=0.
REQ-013 After a granted read, the same client's rvalid SHALL be 1 for exactly the next cycle, with rdata=mem_dout; latency is 1.
REQ-014 rvalid SHALL be 0 on writes and idle cycles; rdata SHALL hold its last value otherwise.
REQ-015 A read and a write to the same address in consecutive cycles SHALL return the RAM's pre-write data per RAM read-first behaviour; the controller SHALL add no forwarding.
REQ-016 clear_start in ARB SHALL enter CLEAR on the next edge; any grant in that same cycle SHALL still complete, including its rvalid.
REQ-017 In CLEAR, the controller SHALL write FILL_VAL to address cnt each cycle (mem_we=1), with cnt running 0..DEPTH_MEM-1.
REQ-018 In CLEAR, no gnt SHALL be asserted and requests SHALL stall.
REQ-019 On cnt==DEPTH_MEM-1, the controller SHALL write that word and return to ARB the next cycle; the sweep takes exactly DEPTH_MEM cycles.
REQ-020 clear_start during CLEAR SHALL be ignored; there SHALL be no restart.
REQ-021 busy SHALL equal (state==CLEAR), registered.
REQ-022 When idle, mem_we SHALL be 0 and addresses are don't-care but SHALL be driven to 0.

Reset
REQ-023 reset low SHALL asynchronously force state=CLEAR if CLEAR_ON_RESET else ARB, cnt=0, priority=A, all rvalid=0, all rdata=0.
REQ-024 busy SHALL reset to CLEAR_ON_RESET, and gnt/mem_we SHALL be 0 while reset is low.
REQ-025 Reset asserted mid-sweep SHALL abort the sweep; after release, the sweep SHALL restart from address 0.
REQ-026 A pending rvalid at reset SHALL be dropped.

Structure
REQ-027 Package bram_arb_pkg SHALL hold the state enum (ARB, CLEAR) and the client-index type.
REQ-028 The round-robin two-way arbiter SHALL be sub-module rr_arb2 (inputs req[1:0] and a pointer; outputs a one-hot grant).
REQ-029 The RAM SHALL be external; the bench SHALL pair this block with a 1-cycle registered simple-dual-port RAM model with write enable.

Verification
REQ-030 Reset release with CLEAR_ON_RESET=1, DEPTH_MEM=32768, FILL_VAL=0 -> busy high for exactly 32768 cycles, mem_we every cycle with addresses 0..32767, then ARB.
REQ-031 With a_req and b_req both held as reads of 5 and 9 -> grants alternate A,B,A,...; the B read returns word 9 one cycle after b_gnt.
REQ-032 A writes 1 to address 100, then B reads 100 the next cycle -> b_rvalid with b_rdata=1.
REQ-033 clear_start in the same cycle as an A read grant -> a_rvalid the next cycle, busy the next cycle, no grants until the sweep ends.
REQ-034 reset pulsed low at cnt=1000 -> after release, the sweep restarts at address 0 and busy stays high 32768 cycles.
REQ-035 Single requester B with back-to-back writes -> b_gnt every cycle, A priority unaffected by idle cycles.
